// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - FMT_* : 2-bit instruction format codes carried on in_fmt
//   - OP_*  : a few named opcodes used by boot programs
//   - state_t : loader FSM state encoding
//   - field positions of the 32-bit instruction word
package imem_loader_pkg;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_M = 2'd1;
    localparam logic [1:0] FMT_B = 2'd2;
    localparam logic [1:0] FMT_J = 2'd3;

    localparam logic [6:0] OP_NOP  = 7'h00;
    localparam logic [6:0] OP_ADD  = 7'h01;
    localparam logic [6:0] OP_LOAD = 7'h10;
    localparam logic [6:0] OP_BEQ  = 7'h30;

    // Word layout: op=[31:25], dst=[24:20], src1=[19:15], src2=[14:10]
    localparam int OP_LSB   = 25;
    localparam int DST_LSB  = 20;
    localparam int SRC1_LSB = 15;
    localparam int SRC2_LSB = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/imem_loader_encoder.sv
// instr_encoder: combinational packer from instruction fields to the 32-bit word.
//   i_fmt      : format code (FMT_R/M/B/J)
//   i_opcode   : 7-bit opcode
//   i_dst      : destination register
//   i_src1     : first source register
//   i_src2     : second source register
//   i_imm      : 20-bit immediate (bits beyond the format's field are dropped)
//   o_word     : packed instruction word
//   o_imm_err  : immediate had nonzero bits the format cannot carry
module instr_encoder
    import imem_loader_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_dst,
    input  logic [4:0]  i_src1,
    input  logic [4:0]  i_src2,
    input  logic [19:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_imm_err
);

    always_comb begin
        o_word    = '0;
        o_imm_err = 1'b0;
        case (i_fmt)
            FMT_R: begin
                o_word    = {i_opcode, i_dst, i_src1, i_src2, 10'b0};
                o_imm_err = (i_imm != 20'd0);
            end
            FMT_M: begin
                o_word    = {i_opcode, i_dst, i_src1, i_imm[14:0]};
                o_imm_err = (i_imm[19:15] != 5'd0);
            end
            FMT_B: begin
                // Branch splits the immediate around the two source fields.
                o_word    = {i_opcode, i_imm[14:10], i_src1, i_src2, i_imm[9:0]};
                o_imm_err = (i_imm[19:15] != 5'd0);
            end
            default: begin
                // FMT_J: the full 20-bit immediate always fits.
                o_word    = {i_opcode, i_imm[19:15], i_src1, i_imm[14:0]};
                o_imm_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: accepts field-level instruction bundles on a valid/ready stream,
// packs them into 32-bit words and writes them to consecutive imem addresses.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, start_addr    : open a session at start_addr (only while idle)
//   in_valid/in_ready    : bundle handshake; in_fmt..in_imm fields, in_last ends session
//   imem_req/gnt/addr/wdata : write port, request held stable until granted
//   busy, done           : session active, one-cycle completion pulse
//   word_count           : words granted in the current/last session
//   fmt_err              : sticky immediate-overflow flag for the session
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int WORD_STEP = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_dst,
    input  logic [4:0]        in_src1,
    input  logic [4:0]        in_src2,
    input  logic [19:0]       in_imm,
    input  logic              in_last,
    output logic              imem_req,
    input  logic              imem_gnt,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              fmt_err
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_STEP);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    state_t            r_state;
    logic              r_req;
    logic              r_req_last;    // word in the output register is the session's last
    logic              r_last_taken;  // in_last accepted; stop taking bundles
    logic              r_done;
    logic              r_fmt_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;

    logic [31:0]       w_word;
    logic              w_imm_err;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_grant;

    instr_encoder u_encoder (
        .i_fmt     (in_fmt),
        .i_opcode  (in_opcode),
        .i_dst     (in_dst),
        .i_src1    (in_src1),
        .i_src2    (in_src2),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_imm_err (w_imm_err)
    );

    // The single output register may be refilled in the same cycle it drains.
    assign w_in_ready = (r_state == ST_RUN) & ~r_last_taken & (~r_req | imem_gnt);
    assign w_accept   = in_valid & w_in_ready;
    assign w_grant    = r_req & imem_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_req_last   <= 1'b0;
            r_last_taken <= 1'b0;
            r_done       <= 1'b0;
            r_fmt_err    <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_count      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_addr       <= start_addr;
                        r_count      <= '0;
                        r_fmt_err    <= 1'b0;
                        r_last_taken <= 1'b0;
                        r_req_last   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_grant) begin
                        r_addr  <= r_addr + ADDR_STEP;   // wraps modulo 2**ADDR_W
                        r_count <= r_count + CNT_ONE;
                        if (r_req_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    if (w_accept) begin
                        r_req      <= 1'b1;
                        r_wdata    <= w_word;
                        r_req_last <= in_last;
                        if (in_last) begin
                            r_last_taken <= 1'b1;
                        end
                        if (w_imm_err) begin
                            r_fmt_err <= 1'b1;
                        end
                    end else if (w_grant) begin
                        r_req <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_last_taken <= 1'b0;
                    r_req_last   <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign word_count = r_count;
    assign fmt_err    = r_fmt_err;

endmodule
